// File: rtl/cfg_chain_sequencer.sv
// cfg_chain_sequencer
//   Loads one configuration frame into the serial static+dynamic config chain.
//   The parallel frame is shifted out MSB first on sdi while sel is high. The
//   chain's previous contents are captured from sdo into rdbk at the same time.
//   An optional second pass re-shifts the same frame. That pass reads back what
//   was just loaded, and the result is reported on mismatch.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   start_vld  load request; accepted when start_rdy is high
//   start_rdy  high only while idle
//   cfg_data   frame to load, bit TOTAL-1 is shifted first
//   verify_en  sampled with the request: run the readback/verify pass
//   abort      terminate the frame currently being shifted
//   sel        chain shift enable / frame select
//   sdi        serial data into the chain
//   sdo        serial data from the chain's last flop
//   rdbk       bits shifted out of the chain during the last pass(es)
//   busy       high whenever not idle
//   done       one-cycle pulse at the end of a sequence
//   mismatch   verify/abort result, valid with done, held until next accept
module cfg_chain_sequencer #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16,
    parameter int GAP_CYC    = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_vld,
    output logic                               start_rdy,
    input  logic [SIZESRSTAT+SIZESRDYN-1:0]    cfg_data,
    input  logic                               verify_en,
    input  logic                               abort,
    output logic                               sel,
    output logic                               sdi,
    input  logic                               sdo,
    output logic [SIZESRSTAT+SIZESRDYN-1:0]    rdbk,
    output logic                               busy,
    output logic                               done,
    output logic                               mismatch
);

    localparam int TOTAL = SIZESRSTAT + SIZESRDYN;
    localparam int CW    = $clog2(TOTAL);
    localparam int GW    = $clog2(GAP_CYC + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(TOTAL - 1);
    localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_GAP1, S_VRFY, S_GAP2, S_FIN
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     bit_cnt, bit_cnt_next;
    logic [GW-1:0]     gap_cnt, gap_cnt_next;
    logic [TOTAL-1:0]  frame;
    logic              verify;
    logic              aborted;
    logic              accept;
    logic              shifting;
    logic              shift_next;
    logic              sdi_next;
    logic [TOTAL-1:0]  frame_src;
    logic [CW-1:0]     bit_idx;
    logic [TOTAL-1:0]  rdbk_shifted;

    assign start_rdy = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);

    // Next state, counters, and the next serial bit.
    // sel/sdi are registered from the next-state view. Because of that, the
    // first bit is already on sdi in the first LOAD cycle.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        gap_cnt_next = gap_cnt;
        accept       = start_vld && (state == S_IDLE);
        shifting     = (state == S_LOAD) || (state == S_VRFY);

        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next   = S_LOAD;
                    bit_cnt_next = '0;
                end
            end
            S_LOAD, S_VRFY: begin
                if (abort || (bit_cnt == LAST_BIT)) begin
                    state_next   = (state == S_LOAD) ? S_GAP1 : S_GAP2;
                    bit_cnt_next = '0;
                    gap_cnt_next = '0;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            S_GAP1, S_GAP2: begin
                if (gap_cnt == LAST_GAP) begin
                    gap_cnt_next = '0;
                    // An aborted load skips the verify pass entirely.
                    if ((state == S_GAP1) && verify && !aborted)
                        state_next = S_VRFY;
                    else
                        state_next = S_FIN;
                end else begin
                    gap_cnt_next = gap_cnt + 1'b1;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        shift_next   = (state_next == S_LOAD) || (state_next == S_VRFY);
        frame_src    = accept ? cfg_data : frame;
        bit_idx      = LAST_BIT - bit_cnt_next;
        sdi_next     = shift_next ? frame_src[bit_idx] : 1'b0;
        rdbk_shifted = {rdbk[TOTAL-2:0], sdo};
    end

    // State register, serial outputs, frame latch, and readback/verify capture.
    // The mismatch compare uses the shifted value so that the final captured
    // bit is included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            frame    <= '0;
            verify   <= 1'b0;
            aborted  <= 1'b0;
            sel      <= 1'b0;
            sdi      <= 1'b0;
            rdbk     <= '0;
            mismatch <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            gap_cnt <= gap_cnt_next;
            sel     <= shift_next;
            sdi     <= sdi_next;
            if (accept) begin
                frame    <= cfg_data;
                verify   <= verify_en;
                aborted  <= 1'b0;
                mismatch <= 1'b0;
                rdbk     <= '0;
            end else begin
                if (sel)
                    rdbk <= rdbk_shifted;
                if (shifting && abort) begin
                    aborted  <= 1'b1;
                    mismatch <= 1'b1;
                end else if ((state == S_VRFY) && (bit_cnt == LAST_BIT)) begin
                    mismatch <= (rdbk_shifted != frame);
                end
            end
        end
    end

endmodule

// File: tb/tb_cfg_chain_sequencer.sv
// tb_cfg_chain_sequencer
//   Drives frames into cfg_chain_sequencer. The config chain is modelled here
//   as a TOTAL-bit shift register whose last flop drives sdo.
//   Expected results (readback, mismatch, latency, sel-high count, final chain
//   contents) are predicted from whole-frame arithmetic and queued per request.
//   A monitor pops the queue on every done pulse.
module tb_cfg_chain_sequencer;

    localparam int SS = 88;
    localparam int SD = 16;
    localparam int T  = SS + SD;
    localparam int G  = 4;

    typedef struct {
        logic [T-1:0] rdbk;
        logic         mm;
        logic [T-1:0] chain;
        int           lat;
        int           selc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_vld;
    logic         start_rdy;
    logic [T-1:0] cfg_data;
    logic         verify_en;
    logic         abort;
    logic         sel;
    logic         sdi;
    logic         sdo;
    logic [T-1:0] rdbk;
    logic         busy;
    logic         done;
    logic         mismatch;

    logic [T-1:0] chain = '0;
    logic         flip_req = 1'b0;
    logic [T-1:0] model_chain = '0;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    int   in_frame = 0;
    int   cyc = 0;
    int   selc = 0;
    int   rdy_bad = 0;
    int   rdy_pending = 0;

    cfg_chain_sequencer #(.SIZESRSTAT(SS), .SIZESRDYN(SD), .GAP_CYC(G)) dut (
        .clk(clk), .rst(rst), .start_vld(start_vld), .start_rdy(start_rdy),
        .cfg_data(cfg_data), .verify_en(verify_en), .abort(abort),
        .sel(sel), .sdi(sdi), .sdo(sdo), .rdbk(rdbk),
        .busy(busy), .done(done), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    // Chain model: shifts while sel is high; a flip request corrupts bit 50.
    always @(posedge clk) begin
        if (sel)
            chain <= {chain[T-2:0], sdi};
        else if (flip_req)
            chain[50] <= ~chain[50];
    end
    assign sdo = chain[T-1];

    task automatic checkOutput(input string name, input logic [T-1:0] act, input logic [T-1:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Whole-frame prediction. mode: 0 full sequence, 1 abort in LOAD at bit k,
    // 2 abort in VRFY at bit k, 3 reset in VRFY at bit k (chain effect only).
    function automatic exp_t predict(input logic [T-1:0] frame, input logic [T-1:0] old,
                                     input bit ver, input int mode, input int k, input bit flip);
        exp_t e;
        logic [T-1:0] pre;
        int m;
        pre = frame;
        if (flip) pre[50] = ~pre[50];
        m = k + 1;
        e.mm = 1'b1;
        case (mode)
            0: begin
                if (!ver) begin
                    e.rdbk = old; e.chain = frame; e.mm = 1'b0;
                    e.selc = T;   e.lat = T + G + 2;
                end else begin
                    e.rdbk = pre; e.chain = frame; e.mm = (pre != frame);
                    e.selc = 2*T; e.lat = 2*T + 2*G + 2;
                end
            end
            1: begin
                e.rdbk  = old >> (T - m);
                e.chain = (old << m) | (frame >> (T - m));
                e.selc  = m;
                e.lat   = m + G + 2;
            end
            default: begin
                e.rdbk  = (old << m) | (pre >> (T - m));
                e.chain = (pre << m) | (frame >> (T - m));
                e.selc  = T + m;
                e.lat   = T + 2*G + m + 2;
            end
        endcase
        return e;
    endfunction

    // Monitor: tracks each accepted frame and scores it on done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            in_frame    = 0;
            rdy_pending = 0;
        end else begin
            if (rdy_pending != 0) begin
                checkOutput("rdy_after_done", T'(start_rdy), T'(1));
                rdy_pending = 0;
            end
            if (in_frame != 0) begin
                cyc++;
                if (sel) selc++;
                if (start_rdy) rdy_bad++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("[TB] FAIL unexpected_done: got done=1 expected no pending frame");
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("rdbk",      rdbk,          e.rdbk);
                        checkOutput("mismatch",  T'(mismatch),  T'(e.mm));
                        checkOutput("latency",   T'(cyc + 1),   T'(e.lat));
                        checkOutput("sel_count", T'(selc),      T'(e.selc));
                        checkOutput("chain",     chain,         e.chain);
                        checkOutput("rdy_busy",  T'(rdy_bad),   T'(0));
                        checkOutput("busy_done", T'(busy),      T'(1));
                    end
                    in_frame    = 0;
                    rdy_pending = 1;
                end
            end
            if (start_vld && start_rdy) begin
                in_frame = 1; cyc = 0; selc = 0; rdy_bad = 0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_sel"},      T'(sel),       T'(0));
        checkOutput({tag, "_sdi"},      T'(sdi),       T'(0));
        checkOutput({tag, "_busy"},     T'(busy),      T'(0));
        checkOutput({tag, "_done"},     T'(done),      T'(0));
        checkOutput({tag, "_mismatch"}, T'(mismatch),  T'(0));
        checkOutput({tag, "_rdbk"},     rdbk,          '0);
        checkOutput({tag, "_rdy"},      T'(start_rdy), T'(1));
    endtask

    task automatic applyStimulus(input logic [T-1:0] frame, input bit ver, input int mode,
                                 input int k, input bit flip, input bit hold);
        exp_t e;
        int guard;
        int el;
        int target;
        guard = 0;
        while (!start_rdy && guard < 2000) begin
            @(posedge clk); #1; guard++;
        end
        if (!start_rdy) begin
            checks++; failures++;
            $display("[TB] FAIL wait_rdy: got start_rdy=0 expected 1 within 2000 cycles");
            return;
        end
        e = predict(frame, model_chain, ver, mode, k, flip);
        if (mode != 3) exp_q.push_back(e);
        model_chain = e.chain;
        cfg_data  = frame;
        verify_en = ver;
        start_vld = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_vld = 1'b0;
        el = 0;
        if (flip) begin
            repeat (T) begin @(posedge clk); #1; end
            el = T;
            flip_req = 1'b1;
            @(posedge clk); #1;
            flip_req = 1'b0;
            el++;
        end
        if (mode != 0) begin
            target = (mode == 1) ? k : T + G + k;
            repeat (target - el) begin @(posedge clk); #1; end
            if (mode == 3) begin
                rst = 1'b1;
                @(posedge clk); #1;
                check_reset_outputs("mid_reset");
                rst = 1'b0;
                void'(exp_q.size());
                return;
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            checkOutput("abort_sel_drop", T'(sel),  T'(0));
            checkOutput("abort_busy",     T'(busy), T'(1));
        end
        guard = 0;
        while (!done && guard < 600) begin
            @(posedge clk); #1; guard++;
        end
        if (!done) begin
            checks++; failures++;
            $display("[TB] FAIL wait_done: got done=0 expected 1 within 600 cycles");
        end
        start_vld = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [T-1:0] f1;
        logic [T-1:0] f2;
        logic [T-1:0] fr;
        int r;
        int k;
        bit v;
        int mode;
        int guard;
        f1 = {13{8'hA5}};
        f2 = 104'h12_3456_789A_BCDE_F011_2233_00FF;
        rst = 1'b1; start_vld = 1'b0; cfg_data = '0; verify_en = 1'b0; abort = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(f1, 1'b0, 0, 0, 1'b0, 1'b0);
        applyStimulus(f2, 1'b1, 0, 0, 1'b0, 1'b0);
        applyStimulus(f2, 1'b1, 0, 0, 1'b1, 1'b0);
        applyStimulus(f1, 1'b0, 1, 30, 1'b0, 1'b0);
        fr = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(fr, 1'b0, 0, 0, 1'b0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("single_frame_idle", T'(busy), T'(0));
        fr = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(fr, 1'b1, 3, 60, 1'b0, 1'b0);
        fr = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(fr, 1'b1, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            fr = {$urandom, $urandom, $urandom, $urandom};
            v  = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 7);
            k  = $urandom_range(0, T - 1);
            mode = 0;
            if (r == 5) mode = 1;
            if (r >= 6 && v) mode = 2;
            applyStimulus(fr, v, mode, k, 1'b0, 1'b0);
        end

        guard = 0;
        while ((exp_q.size() != 0 || rdy_pending != 0) && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("[TB] FAIL drain: got %0d pending frames expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
